// File: rtl/router_mcast_pkg.sv
// Shared definitions for the multicast wormhole router: port indices, flit field
// positions and the input-unit state encoding.
package router_mcast_pkg;

    localparam int NORTH     = 0;
    localparam int SOUTH     = 1;
    localparam int WEST      = 2;
    localparam int EAST      = 3;
    localparam int LOCAL     = 4;
    localparam int NUM_PORTS = LOCAL + 1;

    // Field positions are offsets below the flit MSB, so they hold for any FLIT_WIDTH.
    localparam int HEAD_BIT  = 0;
    localparam int TAIL_BIT  = 1;
    localparam int ROUTE_LSB = 6;

    typedef logic [NUM_PORTS-1:0] route_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_GRANT,
        FWD,
        RELEASE
    } in_state_e;

endpackage

// File: rtl/router_mcast_fifo.sv
// Show-ahead FIFO buffering flits on a router input port; the head entry is
// visible on rdata_o with no added latency.
module router_mcast_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign rdata_o = mem[rd_ptr_q];

    // A full FIFO may still take a push when a pop frees the slot in the same cycle.
    assign push_ok = push_i & (~full_o | pop_i);
    assign pop_ok  = pop_i & ~empty_o;

    always_comb begin
        // NOTE: default first so every path assigns count_d and no latch is inferred.
        count_d = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + 1'b1;
        end else if (!push_ok && pop_ok) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments keep all register updates on the same edge.
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    // NOTE: storage is not reset; the count and pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/router_mcast_input_unit.sv
// Router input port: buffers flits, requests every output named in the head's route
// mask, and moves each flit to all of those outputs together or not at all.
module router_mcast_input_unit
    import router_mcast_pkg::*;
#(
    parameter int FLIT_WIDTH = 34,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [FLIT_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [4:0]            request,
    input  logic [4:0]            grant,
    output logic [4:0]            forwarding_head,
    output logic [4:0]            forwarding_tail,
    output logic [FLIT_WIDTH-1:0] out_data,
    output logic [4:0]            out_valid,
    input  logic [4:0]            out_ready
);

    localparam int HEAD_POS  = FLIT_WIDTH - 1 - HEAD_BIT;
    localparam int TAIL_POS  = FLIT_WIDTH - 1 - TAIL_BIT;
    localparam int ROUTE_POS = FLIT_WIDTH - 1 - ROUTE_LSB;

    in_state_e             state_q;
    route_t                route_q;
    logic [FLIT_WIDTH-1:0] head_flit;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  pop;
    logic                  is_head;
    logic                  is_tail;
    route_t                flit_route;
    logic                  all_granted;
    logic                  all_ready;

    router_mcast_fifo #(
        .WIDTH (FLIT_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (in_valid & in_ready),
        .wdata_i (in_data),
        .pop_i   (pop),
        .rdata_o (head_flit),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign in_ready    = ~fifo_full;
    assign out_data    = head_flit;
    assign is_head     = head_flit[HEAD_POS];
    assign is_tail     = head_flit[TAIL_POS];
    assign flit_route  = head_flit[ROUTE_POS +: NUM_PORTS];
    assign all_granted = ((grant & route_q) == route_q);
    assign all_ready   = ((out_ready & route_q) == route_q);

    always_comb begin
        pop             = 1'b0;
        request         = '0;
        out_valid       = '0;
        forwarding_head = '0;
        forwarding_tail = '0;
        unique case (state_q)
            IDLE: begin
                // Stray body flits and heads with an empty mask are discarded.
                pop = ~fifo_empty & (~is_head | (flit_route == '0));
            end
            WAIT_GRANT: begin
                request = route_q;
                if (!fifo_empty && all_granted && all_ready) begin
                    pop             = 1'b1;
                    out_valid       = route_q;
                    forwarding_head = route_q;
                end
            end
            FWD: begin
                request = route_q;
                if (!fifo_empty && all_ready) begin
                    pop       = 1'b1;
                    out_valid = route_q;
                    if (is_tail) forwarding_tail = route_q;
                end
            end
            RELEASE: begin
                request         = route_q;
                forwarding_tail = route_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            route_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (!fifo_empty && is_head && flit_route != '0) begin
                        route_q <= flit_route;
                        state_q <= WAIT_GRANT;
                    end
                end
                WAIT_GRANT: begin
                    // A single-flit packet still needs a separate tail strobe to unlock arbiters.
                    if (pop) state_q <= is_tail ? RELEASE : FWD;
                end
                FWD: begin
                    if (pop && is_tail) state_q <= IDLE;
                end
                RELEASE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_router_mcast_input_unit.sv
// Directed bench for router_mcast_input_unit: unicast, multicast, single-flit,
// stalls, drops, FIFO full/wrap and mid-packet reset.
module tb_router_mcast_input_unit;
    import router_mcast_pkg::*;

    localparam int FW    = 34;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [FW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [4:0]    request;
    logic [4:0]    grant;
    logic [4:0]    forwarding_head;
    logic [4:0]    forwarding_tail;
    logic [FW-1:0] out_data;
    logic [4:0]    out_valid;
    logic [4:0]    out_ready;

    int n_tests = 0;
    int n_fail  = 0;

    router_mcast_input_unit #(
        .FLIT_WIDTH (FW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .in_data         (in_data),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .request         (request),
        .grant           (grant),
        .forwarding_head (forwarding_head),
        .forwarding_tail (forwarding_tail),
        .out_data        (out_data),
        .out_valid       (out_valid),
        .out_ready       (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [FW-1:0] mk(input logic h, input logic t,
                                         input logic [4:0] r, input logic [26:0] p);
        return {h, t, r, p};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_flit(input logic [FW-1:0] f);
        in_valid = 1'b1;
        in_data  = f;
        cyc();
        in_valid = 1'b0;
    endtask

    // Settles the current cycle's combinational outputs, then compares the strobes.
    task automatic expect_o(input string tag, input logic [4:0] req, input logic [4:0] ov,
                            input logic [4:0] fh, input logic [4:0] ft);
        #1;
        check({tag, ".request"}, request, req);
        check({tag, ".out_valid"}, out_valid, ov);
        check({tag, ".fwd_head"}, forwarding_head, fh);
        check({tag, ".fwd_tail"}, forwarding_tail, ft);
    endtask

    logic [FW-1:0] fl_h, fl_b, fl_b2, fl_t, fl_x;
    logic [FW-1:0] wrap_flits [20];
    logic [4:0]    wrap_route [20];
    int            sent;
    int            got;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        grant     = '0;
        out_ready = '0;
        cyc();
        cyc();
        expect_o("reset", 5'b0, 5'b0, 5'b0, 5'b0);
        check("reset.in_ready", in_ready, 1'b1);
        rst = 1'b0;

        // Unicast 3-flit packet to output 2.
        fl_h = mk(1'b1, 1'b0, 5'b00100, 27'h11);
        fl_b = mk(1'b0, 1'b0, 5'b0, 27'h12);
        fl_t = mk(1'b0, 1'b1, 5'b0, 27'h13);
        push_flit(fl_h);
        push_flit(fl_b);
        push_flit(fl_t);
        expect_o("uni.wait", 5'b00100, 5'b0, 5'b0, 5'b0);
        grant     = 5'b00100;
        out_ready = 5'b11111;
        expect_o("uni.head", 5'b00100, 5'b00100, 5'b00100, 5'b0);
        check("uni.head_data", out_data, fl_h);
        cyc();
        expect_o("uni.body", 5'b00100, 5'b00100, 5'b0, 5'b0);
        check("uni.body_data", out_data, fl_b);
        cyc();
        expect_o("uni.tail", 5'b00100, 5'b00100, 5'b0, 5'b00100);
        check("uni.tail_data", out_data, fl_t);
        cyc();
        expect_o("uni.after", 5'b0, 5'b0, 5'b0, 5'b0);

        // Multicast 10011 under a partial grant, then a full grant.
        grant = '0;
        fl_h  = mk(1'b1, 1'b0, 5'b10011, 27'h21);
        fl_t  = mk(1'b0, 1'b1, 5'b0, 27'h22);
        push_flit(fl_h);
        push_flit(fl_t);
        grant = 5'b00011;
        for (int i = 0; i < 4; i++) begin
            expect_o("mc.partial", 5'b10011, 5'b0, 5'b0, 5'b0);
            cyc();
        end
        grant = 5'b10011;
        expect_o("mc.head", 5'b10011, 5'b10011, 5'b10011, 5'b0);
        check("mc.head_data", out_data, fl_h);
        cyc();
        expect_o("mc.tail", 5'b10011, 5'b10011, 5'b0, 5'b10011);
        cyc();
        expect_o("mc.after", 5'b0, 5'b0, 5'b0, 5'b0);

        // Single-flit packet: head strobe, then a separate release cycle.
        grant = '0;
        fl_h  = mk(1'b1, 1'b1, 5'b01000, 27'h31);
        push_flit(fl_h);
        cyc();
        grant = 5'b01000;
        expect_o("single.head", 5'b01000, 5'b01000, 5'b01000, 5'b0);
        cyc();
        expect_o("single.release", 5'b01000, 5'b0, 5'b0, 5'b01000);
        cyc();
        expect_o("single.idle", 5'b0, 5'b0, 5'b0, 5'b0);

        // FWD stalls while any routed output is not ready; grant is ignored.
        grant     = '0;
        out_ready = '0;
        fl_h = mk(1'b1, 1'b0, 5'b10011, 27'h41);
        fl_b = mk(1'b0, 1'b0, 5'b0, 27'h42);
        fl_t = mk(1'b0, 1'b1, 5'b0, 27'h43);
        push_flit(fl_h);
        push_flit(fl_b);
        push_flit(fl_t);
        grant     = 5'b10011;
        out_ready = 5'b11111;
        expect_o("stall.head", 5'b10011, 5'b10011, 5'b10011, 5'b0);
        cyc();
        grant     = '0;
        out_ready = 5'b10001;
        expect_o("stall.partial0", 5'b10011, 5'b0, 5'b0, 5'b0);
        check("stall.hold_data", out_data, fl_b);
        cyc();
        expect_o("stall.partial1", 5'b10011, 5'b0, 5'b0, 5'b0);
        cyc();
        out_ready = 5'b00010;
        expect_o("stall.partial2", 5'b10011, 5'b0, 5'b0, 5'b0);
        cyc();
        out_ready = 5'b10011;
        expect_o("stall.body", 5'b10011, 5'b10011, 5'b0, 5'b0);
        check("stall.body_data", out_data, fl_b);
        cyc();
        expect_o("stall.tail", 5'b10011, 5'b10011, 5'b0, 5'b10011);
        check("stall.tail_data", out_data, fl_t);
        cyc();
        expect_o("stall.after", 5'b0, 5'b0, 5'b0, 5'b0);

        // Fill to DEPTH, then a pop while full must not open in_ready that cycle.
        grant     = '0;
        out_ready = '0;
        fl_h  = mk(1'b1, 1'b0, 5'b00001, 27'h51);
        fl_b  = mk(1'b0, 1'b0, 5'b0, 27'h52);
        fl_b2 = mk(1'b0, 1'b0, 5'b0, 27'h53);
        fl_t  = mk(1'b0, 1'b1, 5'b0, 27'h54);
        fl_x  = mk(1'b1, 1'b1, 5'b00010, 27'h55);
        push_flit(fl_h);
        push_flit(fl_b);
        push_flit(fl_b2);
        push_flit(fl_t);
        #1;
        check("full.in_ready", in_ready, 1'b0);
        in_valid  = 1'b1;
        in_data   = fl_x;
        grant     = 5'b00001;
        out_ready = 5'b11111;
        expect_o("full.pop_head", 5'b00001, 5'b00001, 5'b00001, 5'b0);
        check("full.in_ready_on_pop", in_ready, 1'b0);
        cyc();
        expect_o("full.push_pop", 5'b00001, 5'b00001, 5'b0, 5'b0);
        check("full.in_ready_after", in_ready, 1'b1);
        check("full.body_data", out_data, fl_b);
        cyc();
        in_valid = 1'b0;
        expect_o("full.body2", 5'b00001, 5'b00001, 5'b0, 5'b0);
        check("full.body2_data", out_data, fl_b2);
        cyc();
        expect_o("full.tail", 5'b00001, 5'b00001, 5'b0, 5'b00001);
        cyc();
        expect_o("full.idle", 5'b0, 5'b0, 5'b0, 5'b0);
        cyc();
        grant = 5'b11111;
        expect_o("full.next_head", 5'b00010, 5'b00010, 5'b00010, 5'b0);
        check("full.next_data", out_data, fl_x);
        cyc();
        expect_o("full.next_release", 5'b00010, 5'b0, 5'b0, 5'b00010);
        cyc();

        // Route-0 heads and stray body flits are dropped silently.
        grant     = '0;
        out_ready = '0;
        push_flit(mk(1'b1, 1'b0, 5'b0, 27'h61));
        push_flit(mk(1'b0, 1'b1, 5'b0, 27'h62));
        expect_o("drop.idle", 5'b0, 5'b0, 5'b0, 5'b0);
        cyc();
        fl_h = mk(1'b1, 1'b1, 5'b10000, 27'h63);
        push_flit(fl_h);
        expect_o("drop.latch", 5'b0, 5'b0, 5'b0, 5'b0);
        cyc();
        grant     = 5'b11111;
        out_ready = 5'b11111;
        expect_o("drop.good_head", 5'b10000, 5'b10000, 5'b10000, 5'b0);
        check("drop.good_data", out_data, fl_h);
        cyc();
        cyc();

        // Ten back-to-back 2-flit packets stream through, wrapping the pointers.
        for (int p = 0; p < 10; p++) begin
            wrap_flits[2*p]   = mk(1'b1, 1'b0, 5'(p + 1), 27'(32'h700 + 2*p));
            wrap_flits[2*p+1] = mk(1'b0, 1'b1, 5'b0, 27'(32'h701 + 2*p));
            wrap_route[2*p]   = 5'(p + 1);
            wrap_route[2*p+1] = 5'(p + 1);
        end
        sent = 0;
        got  = 0;
        for (int c = 0; c < 300 && got < 20; c++) begin
            in_valid = (sent < 20);
            in_data  = wrap_flits[(sent < 20) ? sent : 0];
            #1;
            if (out_valid != 5'b0) begin
                check("wrap.data", out_data, wrap_flits[got]);
                check("wrap.valid", out_valid, wrap_route[got]);
                got++;
            end
            if (in_valid && in_ready) sent++;
            cyc();
        end
        in_valid = 1'b0;
        check("wrap.flit_count", got, 20);

        // Reset in the middle of a packet aborts it.
        grant     = '0;
        out_ready = '0;
        push_flit(mk(1'b1, 1'b0, 5'b00110, 27'h81));
        push_flit(mk(1'b0, 1'b0, 5'b0, 27'h82));
        push_flit(mk(1'b0, 1'b1, 5'b0, 27'h83));
        grant     = 5'b11111;
        out_ready = 5'b11111;
        expect_o("rst.head", 5'b00110, 5'b00110, 5'b00110, 5'b0);
        cyc();
        out_ready = '0;
        expect_o("rst.in_fwd", 5'b00110, 5'b0, 5'b0, 5'b0);
        rst = 1'b1;
        cyc();
        rst       = 1'b0;
        out_ready = 5'b11111;
        expect_o("rst.after", 5'b0, 5'b0, 5'b0, 5'b0);
        check("rst.in_ready", in_ready, 1'b1);
        cyc();
        expect_o("rst.stays_idle", 5'b0, 5'b0, 5'b0, 5'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
